// File: rtl/varredura_display.sv
// Digit-scan controller for the multiplexed 7-segment display.
// Synchronises the divider scan strobe, steps a digit index with dead time
// between digits and drives active-low anodes/segments from a per-frame
// snapshot of the digit nibbles.
module varredura_display #(
    parameter int NUM_DIG      = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Sel,
    input  logic [15:0]        digitos,
    input  logic [3:0]         pontos,
    input  logic               apagar_zeros,
    output logic [NUM_DIG-1:0] anodos,
    output logic [6:0]         segmentos,
    output logic               ponto,
    output logic [1:0]         digito_ativo,
    output logic               tick_varredura
);

    typedef enum logic {EXIBE, PAUSA} estado_t;

    // Power-up behaves like a dead-time interval, so the first digit lights
    // only after the counter drains.
    localparam estado_t    ESTADO_RESET = (BLANK_CYCLES == 0) ? EXIBE : PAUSA;
    localparam logic [7:0] CNT_RESET    = 8'(BLANK_CYCLES);
    localparam logic [7:0] CNT_RELOAD   = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);
    localparam logic [1:0] ULTIMO       = 2'(NUM_DIG - 1);

    logic       s1, s2, s3;
    logic       tick;

    estado_t    estado, estado_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] indice, indice_n;
    logic [15:0] snap_dig, snap_dig_n;
    logic [3:0]  snap_pt, snap_pt_n;

    logic [NUM_DIG-1:0] anodos_n;
    logic [6:0]         segmentos_n;
    logic               ponto_n;
    logic               apaga_n;

    // Standard a..g patterns, active-high; inverted at the output.
    function automatic logic [6:0] decodifica(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    // A digit is a leading zero when it and every more significant nibble is
    // zero; a requested decimal point keeps it visible, digit 0 always shows.
    function automatic logic eh_zero_esq(input logic [1:0] i, input logic [15:0] d,
                                         input logic [3:0] p, input logic en);
        logic zeros;
        zeros = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(i) && d[4*j +: 4] != 4'h0)
                zeros = 1'b0;
        end
        return en && (i != 2'd0) && zeros && !p[i];
    endfunction

    // Two-flop synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Sel;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // Next-state logic: advance on a tick in EXIBE, drain dead time in PAUSA
    // (ticks arriving there are ignored), refresh the snapshot on wrap to 0.
    always_comb begin
        estado_n   = estado;
        cnt_n      = cnt;
        indice_n   = indice;
        snap_dig_n = snap_dig;
        snap_pt_n  = snap_pt;
        case (estado)
            EXIBE: begin
                if (tick) begin
                    if (indice == ULTIMO) begin
                        indice_n   = 2'd0;
                        snap_dig_n = digitos;
                        snap_pt_n  = pontos;
                    end else begin
                        indice_n = indice + 2'd1;
                    end
                    if (BLANK_CYCLES != 0) begin
                        estado_n = PAUSA;
                        cnt_n    = CNT_RELOAD;
                    end
                end
            end
            default: begin
                if (cnt == 8'd0)
                    estado_n = EXIBE;
                else
                    cnt_n = cnt - 8'd1;
            end
        endcase
    end

    // Output values derived from next-state so they move with the FSM.
    always_comb begin
        apaga_n     = eh_zero_esq(indice_n, snap_dig_n, snap_pt_n, apagar_zeros);
        anodos_n    = '1;
        segmentos_n = 7'h7F;
        ponto_n     = 1'b1;
        if (estado_n == EXIBE && !apaga_n) begin
            anodos_n[indice_n] = 1'b0;
            segmentos_n        = ~decodifica(snap_dig_n[{indice_n, 2'b00} +: 4]);
            ponto_n            = ~snap_pt_n[indice_n];
        end
    end

    // Scan FSM state, snapshot and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= ESTADO_RESET;
            cnt            <= CNT_RESET;
            indice         <= 2'd0;
            snap_dig       <= 16'h0000;
            snap_pt        <= 4'h0;
            anodos         <= '1;
            segmentos      <= 7'h7F;
            ponto          <= 1'b1;
            digito_ativo   <= 2'd0;
            tick_varredura <= 1'b0;
        end else begin
            estado         <= estado_n;
            cnt            <= cnt_n;
            indice         <= indice_n;
            snap_dig       <= snap_dig_n;
            snap_pt        <= snap_pt_n;
            anodos         <= anodos_n;
            segmentos      <= segmentos_n;
            ponto          <= ponto_n;
            digito_ativo   <= indice_n;
            tick_varredura <= tick;
        end
    end

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display: a B=2 instance is checked through
// reset, scan order, leading-zero blanking, snapshot update, dropped ticks
// and mid-scan reset; a B=0 instance shares the inputs for the no-dead-time case.
`timescale 1ns/1ps
module tb_varredura_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        Sel;
    logic [15:0] digitos;
    logic [3:0]  pontos;
    logic        apagar_zeros;

    logic [3:0]  anodos, anodos0;
    logic [6:0]  segmentos, segmentos0;
    logic        ponto, ponto0;
    logic [1:0]  digito_ativo, digito_ativo0;
    logic        tick_varredura, tick_varredura0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       pt;
        logic [1:0] idx;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    varredura_display #(.NUM_DIG(4), .BLANK_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .Sel(Sel), .digitos(digitos), .pontos(pontos),
        .apagar_zeros(apagar_zeros), .anodos(anodos), .segmentos(segmentos),
        .ponto(ponto), .digito_ativo(digito_ativo), .tick_varredura(tick_varredura)
    );

    varredura_display #(.NUM_DIG(4), .BLANK_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .Sel(Sel), .digitos(digitos), .pontos(pontos),
        .apagar_zeros(apagar_zeros), .anodos(anodos0), .segmentos(segmentos0),
        .ponto(ponto0), .digito_ativo(digito_ativo0), .tick_varredura(tick_varredura0)
    );

    // Active-low expected segment value for a nibble.
    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return ~tab[n];
    endfunction

    function automatic logic [3:0] an(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One Sel rise, checking latency, dead time and the digit finally shown.
    task automatic scan_step(input logic [1:0] idx, input logic [3:0] ean,
                             input logic [6:0] eseg, input logic ept, input logic chk0);
        exp_t e;
        logic [1:0] prev;
        prev = idx - 2'd1;
        sb.push_back('{ean, eseg, ept, idx});
        @(negedge clock);
        Sel = 1'b1;
        cyc();  // edge k
        cyc();  // edge k+1: tick internal, outputs not yet moved
        chk("pre_tick", {15'd0, tick_varredura}, 16'd0);
        chk("pre_idx", {14'd0, digito_ativo}, {14'd0, prev});
        cyc();  // edge k+2: index change, dead time begins
        chk("dead1_an", {12'd0, anodos}, 16'h000F);
        chk("dead1_seg", {9'd0, segmentos}, 16'h007F);
        chk("new_idx", {14'd0, digito_ativo}, {14'd0, idx});
        chk("tick_pulse", {15'd0, tick_varredura}, 16'd1);
        if (chk0) begin
            chk("b0_an", {12'd0, anodos0}, {12'd0, ean});
            chk("b0_seg", {9'd0, segmentos0}, {9'd0, eseg});
        end
        cyc();  // edge k+3
        chk("dead2_an", {12'd0, anodos}, 16'h000F);
        chk("tick_once", {15'd0, tick_varredura}, 16'd0);
        if (chk0)
            chk("b0_an_hold", {12'd0, anodos0}, {12'd0, ean});
        Sel = 1'b0;
        cyc();  // edge k+4: digit enabled
        e = sb.pop_front();
        chk("show_an", {12'd0, anodos}, {12'd0, e.an});
        chk("show_seg", {9'd0, segmentos}, {9'd0, e.seg});
        chk("show_pt", {15'd0, ponto}, {15'd0, e.pt});
        chk("show_idx", {14'd0, digito_ativo}, {14'd0, e.idx});
        repeat (8) cyc();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        Sel = 1'b0;
        digitos = 16'h0000;
        pontos = 4'h0;
        apagar_zeros = 1'b0;
        repeat (3) cyc();

        // Reset values
        chk("rst_an", {12'd0, anodos}, 16'h000F);
        chk("rst_seg", {9'd0, segmentos}, 16'h007F);
        chk("rst_pt", {15'd0, ponto}, 16'd1);
        chk("rst_idx", {14'd0, digito_ativo}, 16'd0);
        chk("rst_tick", {15'd0, tick_varredura}, 16'd0);
        chk("rst_b0_an", {12'd0, anodos0}, 16'h000F);

        // Release: dead-time counter drains, then digit 0 shows snapshot 0
        reset = 1'b0;
        cyc();
        chk("rel_e1_an", {12'd0, anodos}, 16'h000F);
        chk("rel_b0_an", {12'd0, anodos0}, 16'h000E);
        chk("rel_b0_seg", {9'd0, segmentos0}, 16'h0040);
        cyc();
        chk("rel_e2_an", {12'd0, anodos}, 16'h000F);
        cyc();
        chk("rel_e3_an", {12'd0, anodos}, 16'h000E);
        chk("rel_e3_seg", {9'd0, segmentos}, 16'h0040);
        chk("rel_e3_pt", {15'd0, ponto}, 16'd1);
        repeat (6) cyc();

        // Scan order; old snapshot until the first wrap
        digitos = 16'h1234;
        scan_step(2'd1, an(1), seg(4'h0), 1'b1, 1'b1);
        scan_step(2'd2, an(2), seg(4'h0), 1'b1, 1'b1);
        scan_step(2'd3, an(3), seg(4'h0), 1'b1, 1'b1);
        scan_step(2'd0, an(0), seg(4'h4), 1'b1, 1'b1);
        scan_step(2'd1, an(1), seg(4'h3), 1'b1, 1'b1);
        scan_step(2'd2, an(2), seg(4'h2), 1'b1, 1'b1);
        scan_step(2'd3, an(3), seg(4'h1), 1'b1, 1'b1);
        scan_step(2'd0, an(0), seg(4'h4), 1'b1, 1'b1);

        // Leading-zero blanking
        digitos = 16'h0050;
        apagar_zeros = 1'b1;
        scan_step(2'd1, an(1), seg(4'h3), 1'b1, 1'b0);
        scan_step(2'd2, an(2), seg(4'h2), 1'b1, 1'b0);
        scan_step(2'd3, an(3), seg(4'h1), 1'b1, 1'b0);
        scan_step(2'd0, an(0), seg(4'h0), 1'b1, 1'b0);
        scan_step(2'd1, an(1), seg(4'h5), 1'b1, 1'b0);
        scan_step(2'd2, 4'hF, 7'h7F, 1'b1, 1'b0);
        scan_step(2'd3, 4'hF, 7'h7F, 1'b1, 1'b0);
        pontos = 4'b0100;
        scan_step(2'd0, an(0), seg(4'h0), 1'b1, 1'b0);
        scan_step(2'd1, an(1), seg(4'h5), 1'b1, 1'b0);
        scan_step(2'd2, an(2), seg(4'h0), 1'b0, 1'b0);
        scan_step(2'd3, 4'hF, 7'h7F, 1'b1, 1'b0);

        // Tear-free snapshot
        apagar_zeros = 1'b0;
        pontos = 4'h0;
        digitos = 16'h1111;
        scan_step(2'd0, an(0), seg(4'h1), 1'b1, 1'b0);
        scan_step(2'd1, an(1), seg(4'h1), 1'b1, 1'b0);
        scan_step(2'd2, an(2), seg(4'h1), 1'b1, 1'b0);
        digitos = 16'h2222;
        scan_step(2'd3, an(3), seg(4'h1), 1'b1, 1'b0);
        scan_step(2'd0, an(0), seg(4'h2), 1'b1, 1'b0);
        scan_step(2'd1, an(1), seg(4'h2), 1'b1, 1'b0);

        // Second Sel rise two cycles after the first is dropped
        sb.push_back('{an(2), seg(4'h2), 1'b1, 2'd2});
        @(negedge clock);
        Sel = 1'b1;
        cyc();
        Sel = 1'b0;
        cyc();
        Sel = 1'b1;
        cyc();
        chk("drop_tick1", {15'd0, tick_varredura}, 16'd1);
        chk("drop_idx1", {14'd0, digito_ativo}, 16'd2);
        chk("drop_dead_an", {12'd0, anodos}, 16'h000F);
        cyc();
        chk("drop_gap", {15'd0, tick_varredura}, 16'd0);
        cyc();
        chk("drop_tick2", {15'd0, tick_varredura}, 16'd1);
        e = sb.pop_front();
        chk("drop_show_an", {12'd0, anodos}, {12'd0, e.an});
        chk("drop_show_seg", {9'd0, segmentos}, {9'd0, e.seg});
        chk("drop_show_idx", {14'd0, digito_ativo}, {14'd0, e.idx});
        cyc();
        chk("drop_no_adv", {14'd0, digito_ativo}, 16'd2);
        chk("drop_hold_an", {12'd0, anodos}, {12'd0, an(2)});
        Sel = 1'b0;
        repeat (8) cyc();

        // Reset while on digit 3 in dead time
        @(negedge clock);
        Sel = 1'b1;
        repeat (3) @(posedge clock);
        #3;
        chk("mid_pre_idx", {14'd0, digito_ativo}, 16'd3);
        chk("mid_pre_an", {12'd0, anodos}, 16'h000F);
        reset = 1'b1;
        Sel = 1'b0;
        #1;
        chk("mid_rst_idx", {14'd0, digito_ativo}, 16'd0);
        chk("mid_rst_an", {12'd0, anodos}, 16'h000F);
        chk("mid_rst_seg", {9'd0, segmentos}, 16'h007F);
        chk("mid_rst_pt", {15'd0, ponto}, 16'd1);
        chk("mid_rst_tick", {15'd0, tick_varredura}, 16'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) cyc();
        chk("post_rst_an", {12'd0, anodos}, 16'h000E);
        chk("post_rst_seg", {9'd0, segmentos}, 16'h0040);
        repeat (6) cyc();
        scan_step(2'd1, an(1), seg(4'h0), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
